// File: rtl/key_step_sampler.sv
// -----------------------------------------------------------------------------
// key_step_sampler
//
// Front end for the bit-serial sequence detector. A raw active-low pushbutton
// is synchronized and debounced into exactly one single-cycle step strobe per
// press. At the strobe edge the synchronized switch level is captured as the
// serial data bit. Accepted steps are counted for display.
//
// Optional feature (macro KEY_STEP_AUTO_REPEAT_EN):
//   defined   - while the key is held, another strobe is emitted every
//               REPEAT_CYCLES clocks after acceptance.
//   undefined - exactly one strobe per press; REPEAT_CYCLES is not used.
//
// Ports:
//   CLOCK_50    in   system clock, all logic on rising edge
//   reset       in   asynchronous, active-high reset
//   key_n       in   raw pushbutton, 0 = pressed, asynchronous
//   sw_in       in   raw switch level (serial data bit), asynchronous
//   bit_valid   out  one-cycle strobe per accepted step
//   bit_out     out  data bit for the step, held between strobes
//   step_count  out  accepted steps, modulo 2^STEP_W
//   busy        out  high whenever the FSM is not in IDLE
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | key released and debounced, waiting for a low key_s
// PRESS_WAIT   | key_s low, counting stable clocks before accepting press
// PRESSED      | press accepted (strobe issued), waiting for key_s high
// RELEASE_WAIT | key_s high, counting stable clocks before accepting release
//
// The counter clears on every state change.
// -----------------------------------------------------------------------------
module key_step_sampler #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int STEP_W          = 8,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              key_n,
    input  logic              sw_in,
    output logic              bit_valid,
    output logic              bit_out,
    output logic [STEP_W-1:0] step_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Legal ranges: DEBOUNCE_CYCLES >= 1, REPEAT_CYCLES >= 1. Nothing is built
    // here; out-of-range values simply make this block appear in elaboration.
    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_out_of_range
        end
    endgenerate

    logic key_meta, key_s;
    logic sw_meta, sw_s;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             strobe;

    // Two-flop synchronizers; key resets to released, switch to 0.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
            sw_meta  <= 1'b0;
            sw_s     <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
            sw_meta  <= sw_in;
            sw_s     <= sw_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            step_count <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_valid <= strobe;
            busy      <= (state_nxt != IDLE);
            if (strobe) begin
                bit_out    <= sw_s;
                step_count <= step_count + STEP_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        strobe    = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    strobe    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
`ifdef KEY_STEP_AUTO_REPEAT_EN
                else if (cnt == RP_LAST) begin
                    cnt_nxt = '0;
                    strobe  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                // A low here is release bounce: return to PRESSED, no strobe.
                if (!key_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_step_sampler.sv
// -----------------------------------------------------------------------------
// tb_key_step_sampler
//
// Self-checking bench for key_step_sampler with DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=10. A run-length reference model predicts every output after
// every clock: a press is accepted once the synchronized key has been low for
// DEBOUNCE_CYCLES+1 consecutive clocks, a release once it has been high for
// DEBOUNCE_CYCLES+1 consecutive clocks, and with KEY_STEP_AUTO_REPEAT_EN a
// held key repeats every REPEAT_CYCLES clocks.
// -----------------------------------------------------------------------------
module tb_key_step_sampler;

    localparam int D = 4;
    localparam int R = 10;
`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n;
    logic       sw_in;
    logic       bit_valid;
    logic       bit_out;
    logic [7:0] step_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_step_sampler #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4),
        .STEP_W         (8),
        .REPEAT_CYCLES  (R)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .key_n     (key_n),
        .sw_in     (sw_in),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .step_count(step_count),
        .busy      (busy)
    );

    // Reference model state.
    logic key_dly[$];   // raw key_n samples, oldest first; front = key_s
    logic sw_dly[$];
    bit   pressed;
    int   run_low, run_high, held;
    logic       e_valid, e_bit, e_busy;
    logic [7:0] e_cnt;

    task automatic model_reset();
        key_dly  = '{1'b1, 1'b1};
        sw_dly   = '{1'b0, 1'b0};
        pressed  = 0;
        run_low  = 0;
        run_high = 0;
        held     = 0;
        e_valid  = 0;
        e_bit    = 0;
        e_cnt    = 0;
        e_busy   = 0;
    endtask

    task automatic emit(input logic s);
        e_valid = 1'b1;
        e_bit   = s;
        e_cnt   = e_cnt + 8'd1;
    endtask

    // One rising edge: key_s/sw_s are the samples taken two edges earlier.
    task automatic model_edge(input logic kn, input logic sw);
        logic ks, ss;
        ks = key_dly.pop_front();
        ss = sw_dly.pop_front();
        key_dly.push_back(kn);
        sw_dly.push_back(sw);
        e_valid = 1'b0;
        if (!pressed) begin
            if (!ks) begin
                run_low++;
                if (run_low == D + 1) begin
                    pressed  = 1;
                    run_high = 0;
                    held     = 0;
                    emit(ss);
                end
            end else begin
                run_low = 0;
            end
        end else begin
            if (ks) begin
                run_high++;
                if (run_high == D + 1) begin
                    pressed = 0;
                    run_low = 0;
                end
            end else if (run_high > 0) begin
                run_high = 0;
                held     = 0;
            end else begin
                held++;
                if (AUTO && held == R) begin
                    held = 0;
                    emit(ss);
                end
            end
        end
        e_busy = pressed || (run_low > 0);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".bit_valid"},  int'(bit_valid),  int'(e_valid));
        chk({tag, ".bit_out"},    int'(bit_out),    int'(e_bit));
        chk({tag, ".step_count"}, int'(step_count), int'(e_cnt));
        chk({tag, ".busy"},       int'(busy),       int'(e_busy));
    endtask

    task automatic tick(input string tag, input logic kn, input logic sw);
        key_n = kn;
        sw_in = sw;
        @(posedge clk);
        model_edge(kn, sw);
        #1;
        chk_outputs(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_outputs("reset_held");
        reset = 1'b0;
    endtask

    initial begin
        int first_strobe;
        logic [7:0] base;
        logic sw_v;

        reset = 1'b0;
        key_n = 1'b1;
        sw_in = 1'b0;
        model_reset();
        #2;
        apply_reset();

        // Clean press with sw=1; strobe must appear after edge 7.
        first_strobe = 0;
        for (int i = 1; i <= 20; i++) begin
            tick("press1", 1'b0, 1'b1);
            if (bit_valid === 1'b1 && first_strobe == 0) first_strobe = i;
        end
        chk("press1.latency", first_strobe, 7);
        chk("press1.count", int'(step_count), AUTO ? 2 : 1);
        for (int i = 0; i < 10; i++) tick("release1", 1'b1, 1'b1);
        chk("release1.idle", int'(busy), 0);

        // Press bounce: first short run rejected.
        apply_reset();
        begin
            logic [6:0] pat;
            pat = 7'b0010000;   // applied MSB first: 0,0,1,0,0,0,0
            for (int i = 6; i >= 0; i--) tick("bounce", pat[i], 1'b0);
        end
        for (int i = 0; i < 6; i++) tick("bounce_hold", 1'b0, 1'b0);
        chk("bounce.count", int'(step_count), 1);
        chk("bounce.bit", int'(bit_out), 0);

        // Release bounce 1,0,1,1,1,1 then stay high.
        begin
            logic [5:0] pat;
            pat = 6'b101111;
            for (int i = 5; i >= 0; i--) tick("rel_bounce", pat[i], 1'b1);
        end
        for (int i = 0; i < 8; i++) tick("rel_settle", 1'b1, 1'b1);
        chk("rel_bounce.count", int'(step_count), 1);
        chk("rel_bounce.idle", int'(busy), 0);

        // 256 clean presses with alternating sw; counter wraps to start value.
        base = step_count;
        for (int p = 0; p < 256; p++) begin
            sw_v = (p % 2 == 0);
            for (int i = 0; i < 8; i++) tick("multi_press", 1'b0, sw_v);
            chk("multi.bit", int'(bit_out), int'(sw_v));
            for (int i = 0; i < 7; i++) tick("multi_rel", 1'b1, sw_v);
        end
        chk("multi.wrap", int'(step_count), int'(base));

        // Reset in PRESS_WAIT with counter=2; key stays low afterwards.
        for (int i = 0; i < 5; i++) tick("pre_rst", 1'b0, 1'b1);
        chk("pre_rst.busy", int'(busy), 1);
        apply_reset();
        first_strobe = 0;
        for (int i = 1; i <= 10; i++) begin
            tick("post_rst", 1'b0, 1'b1);
            if (bit_valid === 1'b1 && first_strobe == 0) first_strobe = i;
        end
        chk("post_rst.latency", first_strobe, 7);
        for (int i = 0; i < 8; i++) tick("post_rst_rel", 1'b1, 1'b0);

        // Long hold: 7 clocks to acceptance, then 40 held clocks.
        base = step_count;
        for (int i = 0; i < 47; i++) tick("long_hold", 1'b0, i[0]);
        chk("long_hold.delta", int'(step_count - base), AUTO ? 5 : 1);
        for (int i = 0; i < 8; i++) tick("long_rel", 1'b1, 1'b0);

        // Random runs of key level with random switch activity.
        for (int r = 0; r < 400; r++) begin
            logic kv;
            int len;
            kv  = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) tick("random", kv, logic'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
